// File: rtl/ar_rx_word_fifo.sv
// ARINC429 receive word FIFO: edge-detected capture of {label, data}, host read port, fill/overflow flags.
// Optional label-enable filter is compiled in with `define AR_LABEL_FILTER_EN.
module ar_rx_word_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_W      = DEPTH_LOG2 + 1
) (
  input  logic             GCLK,
  input  logic             reset,
  input  logic [7:0]       sr_adr,
  input  logic [22:0]      sr_dat,
  input  logic             ce_wr,
  input  logic             rd_en,
  output logic [7:0]       rd_adr,
  output logic [22:0]      rd_dat,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  input  logic             ovf_clr,
  input  logic             lbl_we,
  input  logic [7:0]       lbl_sel,
  input  logic             lbl_on,
  output logic [15:0]      drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [30:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_ovf;
  logic                  r_ce_d;
  logic [7:0]            r_rd_adr;
  logic [22:0]           r_rd_dat;
  logic                  r_rd_valid;

  logic                  w_wr_req;
  logic                  w_lbl_ok;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_ovf_set;
  logic [CNT_W-1:0]      w_cnt_nxt;

  assign w_wr_req  = ce_wr & ~r_ce_d;
  assign w_rd_acc  = rd_en & ~r_empty;
  // A full FIFO still takes a word when a read frees a slot in the same cycle.
  assign w_wr_acc  = w_wr_req & w_lbl_ok & (~r_full | w_rd_acc);
  assign w_ovf_set = w_wr_req & w_lbl_ok & r_full & ~w_rd_acc;

`ifdef AR_LABEL_FILTER_EN
  logic [255:0] r_lbl_tab;
  logic [15:0]  r_drop_cnt;

  assign w_lbl_ok = r_lbl_tab[sr_adr];

  // label-enable table, all labels accepted after reset
  always_ff @(posedge GCLK) begin
    if (reset) begin
      r_lbl_tab <= '1;
    end else if (lbl_we) begin
      r_lbl_tab[lbl_sel] <= lbl_on;
    end else begin
      r_lbl_tab <= r_lbl_tab;
    end
  end

  // saturating count of words rejected by the label table
  always_ff @(posedge GCLK) begin
    if (reset) begin
      r_drop_cnt <= 16'd0;
    end else if (w_wr_req && !w_lbl_ok && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  logic w_unused_lbl;

  assign w_lbl_ok     = 1'b1;
  assign w_unused_lbl = ^{lbl_we, lbl_sel, lbl_on};
  assign drop_cnt     = 16'd0;
`endif

  // next fill level from accepted write/read
  always_comb begin
    w_cnt_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_cnt_nxt = r_count + CNT_W'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_cnt_nxt = r_count - CNT_W'(1);
    end else begin
      w_cnt_nxt = r_count;
    end
  end

  // word storage, contents not reset
  always_ff @(posedge GCLK) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= {sr_adr, sr_dat};
    end
  end

  // pointers, level, flags, strobe edge detect
  always_ff @(posedge GCLK) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ce_d  <= 1'b0;
    end else begin
      r_ce_d  <= ce_wr;
      r_count <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == CNT_W'(0));
      r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
      if (w_wr_acc) begin
        r_wptr <= r_wptr + DEPTH_LOG2'(1);
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + DEPTH_LOG2'(1);
      end else begin
        r_rptr <= r_rptr;
      end
    end
  end

  // read output register; data holds while no word is delivered
  always_ff @(posedge GCLK) begin
    if (reset) begin
      r_rd_adr   <= 8'd0;
      r_rd_dat   <= 23'd0;
      r_rd_valid <= 1'b0;
    end else if (w_rd_acc) begin
      r_rd_adr   <= r_mem[r_rptr][30:23];
      r_rd_dat   <= r_mem[r_rptr][22:0];
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_adr   <= r_rd_adr;
      r_rd_dat   <= r_rd_dat;
      r_rd_valid <= 1'b0;
    end
  end

  // sticky overflow; a new overflow beats a simultaneous clear
  always_ff @(posedge GCLK) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign rd_adr   = r_rd_adr;
  assign rd_dat   = r_rd_dat;
  assign rd_valid = r_rd_valid;
  assign empty    = r_empty;
  assign full     = r_full;
  assign count    = r_count;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_ar_rx_word_fifo.sv
// Randomized and directed bench for ar_rx_word_fifo against a queue-based reference model.
module tb_ar_rx_word_fifo;

`ifdef AR_LABEL_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        GCLK;
  logic        reset;
  logic [7:0]  sr_adr;
  logic [22:0] sr_dat;
  logic        ce_wr;
  logic        rd_en;
  logic [7:0]  rd_adr;
  logic [22:0] rd_dat;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        ovf;
  logic        ovf_clr;
  logic        lbl_we;
  logic [7:0]  lbl_sel;
  logic        lbl_on;
  logic [15:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [30:0]  q[$];
  bit           m_ce_d;
  bit           m_ovf;
  bit           m_rv;
  logic [7:0]   m_radr;
  logic [22:0]  m_rdat;
  logic [15:0]  m_drop;
  bit [255:0]   m_tab;

  ar_rx_word_fifo #(.DEPTH_LOG2(4), .CNT_W(5)) dut (
    .GCLK(GCLK), .reset(reset), .sr_adr(sr_adr), .sr_dat(sr_dat), .ce_wr(ce_wr),
    .rd_en(rd_en), .rd_adr(rd_adr), .rd_dat(rd_dat), .rd_valid(rd_valid),
    .empty(empty), .full(full), .count(count), .ovf(ovf), .ovf_clr(ovf_clr),
    .lbl_we(lbl_we), .lbl_sel(lbl_sel), .lbl_on(lbl_on), .drop_cnt(drop_cnt)
  );

  initial GCLK = 1'b0;
  always #5 GCLK = ~GCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply current inputs for one clock, advance the model, then compare all outputs.
  task automatic tick();
    bit          wr_req, lbl_ok, rd_ok, full_b;
    logic [30:0] w;
    if (reset) begin
      q.delete();
      m_ce_d = 1'b0; m_ovf = 1'b0; m_rv = 1'b0;
      m_radr = 8'd0; m_rdat = 23'd0; m_drop = 16'd0; m_tab = '1;
    end else begin
      wr_req = ce_wr && !m_ce_d;
      lbl_ok = FILT ? m_tab[sr_adr] : 1'b1;
      full_b = (q.size() == 16);
      rd_ok  = rd_en && (q.size() > 0);
      m_rv   = rd_ok;
      if (rd_ok) begin
        w = q.pop_front();
        m_radr = w[30:23];
        m_rdat = w[22:0];
      end
      if (ovf_clr) m_ovf = 1'b0;
      if (wr_req) begin
        if (!lbl_ok) begin
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end else if (!full_b || rd_ok) begin
          q.push_back({sr_adr, sr_dat});
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (FILT && lbl_we) m_tab[lbl_sel] = lbl_on;
      m_ce_d = ce_wr;
    end
    @(posedge GCLK);
    #1;
    chk("count",    32'(count),    32'(q.size()));
    chk("empty",    32'(empty),    32'(q.size() == 0));
    chk("full",     32'(full),     32'(q.size() == 16));
    chk("ovf",      32'(ovf),      32'(m_ovf));
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("rd_adr",   32'(rd_adr),   32'(m_radr));
    chk("rd_dat",   32'(rd_dat),   32'(m_rdat));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic wr_word(input logic [7:0] a, input logic [22:0] d);
    ce_wr = 1'b1; sr_adr = a; sr_dat = d;
    tick();
    ce_wr = 1'b0;
    tick();
  endtask

  task automatic rd_word();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce_wr = 1'b0; rd_en = 1'b0; sr_adr = 8'd0; sr_dat = 23'd0;
    ovf_clr = 1'b0; lbl_we = 1'b0; lbl_sel = 8'd0; lbl_on = 1'b0;
    m_tab = '1; m_drop = 16'd0;
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);

    // single word round trip
    wr_word(8'h35, 23'h12345A);
    chk("t1_cnt1", 32'(count), 32'd1);
    rd_word();
    chk("t1_valid", 32'(rd_valid), 32'd1);
    chk("t1_adr", 32'(rd_adr), 32'h35);
    chk("t1_dat", 32'(rd_dat), 32'h12345A);
    chk("t1_empty", 32'(empty), 32'd1);
    tick();

    // held strobe writes exactly once
    ce_wr = 1'b1; sr_adr = 8'h10; sr_dat = 23'h000111;
    for (int i = 0; i < 5; i++) tick();
    ce_wr = 1'b0;
    tick();
    chk("t2_cnt1", 32'(count), 32'd1);
    rd_word();
    tick();

    // overfill, drain, second fill across pointer wrap
    for (int i = 0; i < 17; i++) wr_word(8'(i), 23'(i * 3 + 7));
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd_word();
      chk("t3_order", 32'(rd_adr), 32'(i));
    end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    for (int i = 0; i < 10; i++) wr_word(8'(8'h80 + i), 23'(i));
    for (int i = 0; i < 10; i++) rd_word();
    tick();

    // simultaneous write and read when full
    for (int i = 0; i < 16; i++) wr_word(8'(8'h40 + i), 23'(i));
    ce_wr = 1'b1; sr_adr = 8'hEE; sr_dat = 23'h7FFFFF; rd_en = 1'b1;
    tick();
    ce_wr = 1'b0; rd_en = 1'b0;
    chk("t4_cnt16", 32'(count), 32'd16);
    chk("t4_ovf0", 32'(ovf), 32'd0);
    chk("t4_oldest", 32'(rd_adr), 32'h40);
    for (int i = 0; i < 16; i++) rd_word();
    chk("t4_last", 32'(rd_adr), 32'hEE);
    tick();

    // simultaneous write and read when empty
    ce_wr = 1'b1; sr_adr = 8'h55; rd_en = 1'b1;
    tick();
    ce_wr = 1'b0; rd_en = 1'b0;
    chk("t5_cnt1", 32'(count), 32'd1);
    chk("t5_nvalid", 32'(rd_valid), 32'd0);
    rd_word();
    tick();

    // reset with words stored and a read pending
    for (int i = 0; i < 7; i++) wr_word(8'(i), 23'(i));
    reset = 1'b1; rd_en = 1'b1;
    tick();
    reset = 1'b0; rd_en = 1'b0;
    chk("t6_cnt0", 32'(count), 32'd0);
    chk("t6_nvalid", 32'(rd_valid), 32'd0);

    // label filter
    lbl_we = 1'b1; lbl_sel = 8'h20; lbl_on = 1'b0;
    tick();
    lbl_we = 1'b0;
    wr_word(8'h20, 23'd1);
    wr_word(8'h21, 23'd2);
    wr_word(8'h20, 23'd3);
    chk("t7_cnt", 32'(count), FILT ? 32'd1 : 32'd3);
    chk("t7_drop", 32'(drop_cnt), FILT ? 32'd2 : 32'd0);

    // randomized phases alternating write-heavy and read-heavy
    for (int ph = 0; ph < 12; ph++) begin
      for (int c = 0; c < 250; c++) begin
        ce_wr   = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 70 : 30));
        sr_adr  = 8'h20 + 8'($urandom_range(0, 7));
        sr_dat  = 23'($urandom);
        rd_en   = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 15 : 60));
        ovf_clr = ($urandom_range(0, 99) < 5);
        lbl_we  = ($urandom_range(0, 99) < 3);
        lbl_sel = 8'h20 + 8'($urandom_range(0, 7));
        lbl_on  = 1'($urandom_range(0, 1));
        reset   = ($urandom_range(0, 999) < 3);
        tick();
      end
    end
    reset = 1'b0; ce_wr = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; lbl_we = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ar_rx_word_fifo.md
Name: ar_rx_word_fifo

Overview:
- Downstream consumer of the ARINC429 receive path. Captures each received word (8-bit label plus 23-bit data) on the receiver's write strobe.
- Buffers words in a synchronous FIFO for a host or CPU-side reader.
- Reports fill level, empty/full and sticky overflow.
- Sits between the receiver-dispatch output registers and the host bus.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth in words (depth = 16).
- CNT_W, DEPTH_LOG2+1, width of the fill-level count.

Ports:
- GCLK  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- sr_adr  in  8  received label from the receiver.
- sr_dat  in  23  received data field from the receiver.
- ce_wr  in  1  receiver word-ready strobe (level; may stay high for more than one cycle).
- rd_en  in  1  host read request, one word per cycle when high.
- rd_adr  out  8  label of the word read.
- rd_dat  out  23  data of the word read.
- rd_valid  out  1  one-cycle pulse: rd_adr/rd_dat valid.
- empty  out  1  FIFO holds no words.
- full  out  1  FIFO holds 2^DEPTH_LOG2 words.
- count  out  CNT_W  number of stored words.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf.
- lbl_we  in  1  label-table write strobe (used only with the feature).
- lbl_sel  in  8  label-table index.
- lbl_on  in  1  label-table write value.
- drop_cnt  out  16  count of filtered words (0 without the feature).

Behaviour:
- Interface: one clock (GCLK); reset is synchronous and active-high.
- Reset values: rd_adr=0, rd_dat=0, rd_valid=0, empty=1, full=0, count=0, ovf=0, drop_cnt=0. Read/write pointers are cleared.
- Reset mid-operation: all stored words are discarded, and any read in that cycle is lost.
- Write detect:
  - ce_wr is registered into ce_d.
  - wr_req = ce_wr & ~ce_d, so one word is written per ce_wr rising edge however long ce_wr stays high.
  - sr_adr/sr_dat are sampled in the same cycle as the rising edge.
  - ce_d resets to 0, so if ce_wr is high when reset releases, that counts as a rising edge on the first cycle.
- Write path:
  - If wr_req and the FIFO is not full (or a read is accepted in the same cycle), store {sr_adr, sr_dat} at wptr and increment wptr modulo depth.
  - If wr_req while full and no read is accepted, drop the word and set ovf=1. The stored contents are unchanged.
- Read path:
  - If rd_en and not empty: on the next edge, rd_adr/rd_dat are loaded from rptr, rd_valid=1, and rptr increments modulo depth. Latency is 1 cycle from rd_en to rd_valid.
  - If rd_en while empty: ignored, rd_valid=0, rd_adr/rd_dat hold.
  - rd_adr/rd_dat hold their last value while rd_valid=0.
- Simultaneous events:
  - Write and read when empty: the write is stored, the read is ignored, count goes to 1.
  - Write and read when full: both are accepted, count stays at full, ovf is not set.
  - Otherwise: count increments on a write only, decrements on a read only, and is unchanged on both.
- Flags:
  - empty=(count==0), full=(count==2^DEPTH_LOG2), both registered alongside count.
  - Pointer wrap is a natural modulo of the DEPTH_LOG2-bit pointers.
- ovf:
  - Set by an overflow and cleared by ovf_clr.
  - If set and clear happen in the same cycle, set wins.
- Storage: RAM inferred as a register array with no reset on the contents.

Optional Feature:
- AR_LABEL_FILTER_EN
- When defined:
  - A 256x1 label-enable table exists and resets to all 1.
  - On lbl_we, table[lbl_sel] <= lbl_on.
  - A wr_req whose label has table[sr_adr]=0 is not stored and does not affect ovf. drop_cnt increments instead, saturating at 0xFFFF.
  - A table write and a word with the same label in the same cycle: the word uses the old table value.
- When undefined: there is no table, lbl_* ports are ignored, every word is accepted, and drop_cnt is tied to 0.

Test Plan:
- Reset, then a ce_wr pulse with sr_adr=0x35, sr_dat=0x12345A, then rd_en for one cycle -> count 1→0; rd_valid one cycle after rd_en with rd_adr=0x35, rd_dat=0x12345A; empty=1.
- ce_wr held high for 5 cycles with adr=0x10 -> exactly one word stored, count=1.
- 17 write edges, DEPTH_LOG2=4, labels 0..16 -> full=1, count=16, ovf=1. Reading 16 words returns labels 0..15 in order, and the pointer wrap is correct on a second fill.
- Full FIFO, wr_req and rd_en in the same cycle -> count stays 16, ovf stays 0, the oldest word is output and the new word is appended last. Empty FIFO, wr_req and rd_en together -> count=1, rd_valid=0.
- Reset asserted with count=7 and rd_en high -> next cycle count=0, empty=1, rd_valid=0, ovf=0.
- With AR_LABEL_FILTER_EN: lbl_we, lbl_sel=0x20, lbl_on=0, then words with labels 0x20, 0x21, 0x20 -> count=1 (label 0x21), drop_cnt=2. Without the macro, the same stimulus gives count=3, drop_cnt=0.
